// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and whoever drives it.
// The master side raises the soft-reset request and watches the
// per-domain resets; the slave side is the sequencer itself.
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 2
);

    logic                   Req;
    logic [NUM_DOMAINS-1:0] Rst_Out;
    logic                   Busy;
    logic                   Done;

    modport master (
        output Req,
        input  Rst_Out,
        input  Busy,
        input  Done
    );

    modport slave (
        input  Req,
        output Rst_Out,
        output Busy,
        output Done
    );

endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer for the reference clock domain.
//
// On system reset (RST low) or a soft-reset request (Req high) every
// domain reset output is driven low and held for PULSE_WIDTH cycles.
// The domains are then released one at a time in index order, GAP cycles
// apart. Busy is high whenever any domain is still held in reset, and
// Done pulses for a single cycle in the cycle the last domain is released.
//
// A request arriving at any point before the sequence completes restarts
// the whole sequence. Domains that were already released are pulled back
// into reset, so the release order seen downstream is always monotonic:
// bit i is never high while a lower-numbered bit is still low.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 2,
    parameter int PULSE_WIDTH = 16,
    parameter int GAP         = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    reset_sequencer_if.slave  io_bus
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_WIDTH-1:0] PULSE_LAST = CNT_WIDTH'(PULSE_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST   = CNT_WIDTH'(GAP - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_IDLE    = 2'd2
    } StateT;

    StateT                  r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_DOMAINS-1:0] r_rstOut;
    logic                   r_busy;
    logic                   r_done;

    StateT                  w_stateNext;
    logic [CNT_WIDTH-1:0]   w_cntNext;
    logic [IDX_W-1:0]       w_idxNext;
    logic [NUM_DOMAINS-1:0] w_rstOutNext;
    logic                   w_busyNext;
    logic                   w_doneNext;
    logic                   w_req;

    assign w_req = io_bus.Req;

    // State register and registered outputs; RST low overrides everything,
    // including a simultaneous soft-reset request.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= ST_ASSERT;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_rstOut <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_idx    <= w_idxNext;
            r_rstOut <= w_rstOutNext;
            r_busy   <= w_busyNext;
            r_done   <= w_doneNext;
        end
    end

    // Next-state and next-output logic. Every path that changes state also
    // clears the counter, so the counter never runs past its terminal count.
    // Done defaults to zero so it can only ever be a single-cycle pulse.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_idxNext    = r_idx;
        w_rstOutNext = r_rstOut;
        w_doneNext   = 1'b0;

        unique case (r_state)
            ST_ASSERT: begin
                w_rstOutNext = '0;
                if (w_req) begin
                    w_cntNext = '0;
                    w_idxNext = '0;
                end else if (r_cnt == PULSE_LAST) begin
                    w_rstOutNext[0] = 1'b1;
                    w_cntNext       = '0;
                    if (NUM_DOMAINS == 1) begin
                        w_idxNext   = '0;
                        w_stateNext = ST_IDLE;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_idxNext   = IDX_W'(1);
                        w_stateNext = ST_RELEASE;
                    end
                end else begin
                    w_cntNext = r_cnt + CNT_WIDTH'(1);
                end
            end

            ST_RELEASE: begin
                if (w_req) begin
                    w_stateNext  = ST_ASSERT;
                    w_rstOutNext = '0;
                    w_cntNext    = '0;
                    w_idxNext    = '0;
                end else if (r_cnt == GAP_LAST) begin
                    w_cntNext = '0;
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (IDX_W'(i) == r_idx) begin
                            w_rstOutNext[i] = 1'b1;
                        end
                    end
                    if (r_idx == IDX_LAST) begin
                        // The index is parked at zero in IDLE rather than
                        // stepping past the last domain, which would wrap
                        // when NUM_DOMAINS is a power of two.
                        w_idxNext   = '0;
                        w_stateNext = ST_IDLE;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_idxNext = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cntNext = r_cnt + CNT_WIDTH'(1);
                end
            end

            ST_IDLE: begin
                w_rstOutNext = '1;
                w_cntNext    = '0;
                w_idxNext    = '0;
                if (w_req) begin
                    w_stateNext  = ST_ASSERT;
                    w_rstOutNext = '0;
                end
            end

            default: begin
                w_stateNext  = ST_ASSERT;
                w_rstOutNext = '0;
                w_cntNext    = '0;
                w_idxNext    = '0;
            end
        endcase

        w_busyNext = (w_stateNext != ST_IDLE);
    end

    assign io_bus.Rst_Out = r_rstOut;
    assign io_bus.Busy    = r_busy;
    assign io_bus.Done    = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer.
// DUT A uses the default parameters and is driven from a table of
// directed vectors. DUT B (N=1, PW=1, GAP=1) and DUT C (N=4, PW=5, GAP=3)
// cover the parameter corners with hand-written sequences whose expected
// values come from the release-edge formula PW + i*GAP.
module tb_reset_sequencer;

    logic CLK = 1'b0;
    logic rstA;
    logic rstB;
    logic rstC;
    bit   monEnable = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Free-running reference clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    reset_sequencer_if #(.NUM_DOMAINS(2)) busA ();
    reset_sequencer_if #(.NUM_DOMAINS(1)) busB ();
    reset_sequencer_if #(.NUM_DOMAINS(4)) busC ();

    reset_sequencer #(
        .NUM_DOMAINS(2), .PULSE_WIDTH(16), .GAP(4), .CNT_WIDTH(8)
    ) dutA (
        .CLK(CLK), .RST(rstA), .io_bus(busA.slave)
    );

    reset_sequencer #(
        .NUM_DOMAINS(1), .PULSE_WIDTH(1), .GAP(1), .CNT_WIDTH(8)
    ) dutB (
        .CLK(CLK), .RST(rstB), .io_bus(busB.slave)
    );

    reset_sequencer #(
        .NUM_DOMAINS(4), .PULSE_WIDTH(5), .GAP(3), .CNT_WIDTH(8)
    ) dutC (
        .CLK(CLK), .RST(rstC), .io_bus(busC.slave)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       req;
        int         n;
        logic [1:0] expRst;
        logic       expBusy;
        logic       expDone;
    } VecT;

    VecT vecs[$];

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Drives the inputs of DUT A.
    task automatic applyStimulus(input logic rst, input logic req);
        rstA     = rst;
        busA.Req = req;
    endtask

    task automatic addVec(input string name, input logic rst, input logic req,
                          input int n, input logic [1:0] expRst,
                          input logic expBusy, input logic expDone);
        VecT v;
        v.name    = name;
        v.rst     = rst;
        v.req     = req;
        v.n       = n;
        v.expRst  = expRst;
        v.expBusy = expBusy;
        v.expDone = expDone;
        vecs.push_back(v);
    endtask

    task automatic checkB(input int t);
        string tag;
        tag = $sformatf("B t=%0d", t);
        checkOutput({tag, " Rst_Out"}, 32'(busB.Rst_Out), (t >= 1) ? 32'd1 : 32'd0);
        checkOutput({tag, " Busy"}, 32'(busB.Busy), (t >= 1) ? 32'd0 : 32'd1);
        checkOutput({tag, " Done"}, 32'(busB.Done), (t == 1) ? 32'd1 : 32'd0);
    endtask

    task automatic checkC(input int t);
        logic [3:0] exp;
        string tag;
        tag = $sformatf("C t=%0d", t);
        exp = '0;
        for (int i = 0; i < 4; i++) begin
            exp[i] = (t >= 5 + 3 * i);
        end
        checkOutput({tag, " Rst_Out"}, 32'(busC.Rst_Out), 32'(exp));
        checkOutput({tag, " Busy"}, 32'(busC.Busy), (t >= 14) ? 32'd0 : 32'd1);
        checkOutput({tag, " Done"}, 32'(busC.Done), (t == 14) ? 32'd1 : 32'd0);
    endtask

    // Starts a sequence on DUT B from RST or Req and follows it to IDLE.
    task automatic runB(input bit useRst);
        if (useRst) rstB = 1'b0;
        else        busB.Req = 1'b1;
        @(posedge CLK); #1;
        checkB(0);
        rstB     = 1'b1;
        busB.Req = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            @(posedge CLK); #1;
            checkB(t);
        end
    endtask

    // Starts a sequence on DUT C; a nonzero abortAt raises Req at that
    // relative edge once, after which timing restarts from the abort edge.
    task automatic runC(input bit useRst, input int abortAt);
        int t;
        bit aborted;
        aborted = 1'b0;
        if (useRst) rstC = 1'b0;
        else        busC.Req = 1'b1;
        @(posedge CLK); #1;
        checkC(0);
        rstC     = 1'b1;
        busC.Req = 1'b0;
        t = 1;
        while (t <= 18) begin
            if (!aborted && t == abortAt) begin
                busC.Req = 1'b1;
                @(posedge CLK); #1;
                busC.Req = 1'b0;
                checkC(0);
                aborted = 1'b1;
                t = 1;
            end else begin
                @(posedge CLK); #1;
                checkC(t);
                t++;
            end
        end
    endtask

    // Every-cycle invariants on all three instances: Busy mirrors "some
    // domain still in reset" and the released bits always form a
    // contiguous run starting at bit 0.
    always @(negedge CLK) begin
        if (monEnable) begin
            checkOutput("A busy-vs-rst", 32'(busA.Busy), 32'(~&busA.Rst_Out));
            checkOutput("B busy-vs-rst", 32'(busB.Busy), 32'(~&busB.Rst_Out));
            checkOutput("C busy-vs-rst", 32'(busC.Busy), 32'(~&busC.Rst_Out));
            checkOutput("A monotonic", 32'(busA.Rst_Out & (busA.Rst_Out + 2'd1)), 32'd0);
            checkOutput("C monotonic", 32'(busC.Rst_Out & (busC.Rst_Out + 4'd1)), 32'd0);
        end
    end

    initial begin
        rstA = 1'b0; busA.Req = 1'b0;
        rstB = 1'b0; busB.Req = 1'b0;
        rstC = 1'b0; busC.Req = 1'b0;

        // Power-on: RST low 3 edges, last low edge r; release at r+16, r+20.
        addVec("por-low",     1'b0, 1'b0,  3, 2'b00, 1'b1, 1'b0);
        addVec("por-hold",    1'b1, 1'b0, 15, 2'b00, 1'b1, 1'b0);
        addVec("por-rel0",    1'b1, 1'b0,  4, 2'b01, 1'b1, 1'b0);
        addVec("por-done",    1'b1, 1'b0,  1, 2'b11, 1'b0, 1'b1);
        addVec("por-idle",    1'b1, 1'b0,  3, 2'b11, 1'b0, 1'b0);
        // Soft reset from IDLE.
        addVec("soft-req",    1'b1, 1'b1,  1, 2'b00, 1'b1, 1'b0);
        addVec("soft-hold",   1'b1, 1'b0, 15, 2'b00, 1'b1, 1'b0);
        addVec("soft-rel0",   1'b1, 1'b0,  4, 2'b01, 1'b1, 1'b0);
        addVec("soft-done",   1'b1, 1'b0,  1, 2'b11, 1'b0, 1'b1);
        addVec("soft-idle",   1'b1, 1'b0,  2, 2'b11, 1'b0, 1'b0);
        // Retrigger during ASSERT: Req at k and k+10, releases k+26, k+30.
        addVec("retrig-req",  1'b1, 1'b1,  1, 2'b00, 1'b1, 1'b0);
        addVec("retrig-h1",   1'b1, 1'b0,  9, 2'b00, 1'b1, 1'b0);
        addVec("retrig-req2", 1'b1, 1'b1,  1, 2'b00, 1'b1, 1'b0);
        addVec("retrig-h2",   1'b1, 1'b0, 15, 2'b00, 1'b1, 1'b0);
        addVec("retrig-rel0", 1'b1, 1'b0,  4, 2'b01, 1'b1, 1'b0);
        addVec("retrig-done", 1'b1, 1'b0,  1, 2'b11, 1'b0, 1'b1);
        addVec("retrig-idle", 1'b1, 1'b0,  2, 2'b11, 1'b0, 1'b0);
        // Abort in RELEASE at k+18, releases at k+34, k+38.
        addVec("abort-req",   1'b1, 1'b1,  1, 2'b00, 1'b1, 1'b0);
        addVec("abort-hold",  1'b1, 1'b0, 15, 2'b00, 1'b1, 1'b0);
        addVec("abort-rel0",  1'b1, 1'b0,  2, 2'b01, 1'b1, 1'b0);
        addVec("abort-req2",  1'b1, 1'b1,  1, 2'b00, 1'b1, 1'b0);
        addVec("abort-h2",    1'b1, 1'b0, 15, 2'b00, 1'b1, 1'b0);
        addVec("abort-r0b",   1'b1, 1'b0,  4, 2'b01, 1'b1, 1'b0);
        addVec("abort-done",  1'b1, 1'b0,  1, 2'b11, 1'b0, 1'b1);
        addVec("abort-idle",  1'b1, 1'b0,  2, 2'b11, 1'b0, 1'b0);
        // Sync reset mid-release with Req held; timing from last RST-low edge.
        addVec("srst-req",    1'b1, 1'b1,  1, 2'b00, 1'b1, 1'b0);
        addVec("srst-hold",   1'b1, 1'b0, 15, 2'b00, 1'b1, 1'b0);
        addVec("srst-rel0",   1'b1, 1'b0,  1, 2'b01, 1'b1, 1'b0);
        addVec("srst-low",    1'b0, 1'b1,  2, 2'b00, 1'b1, 1'b0);
        addVec("srst-h2",     1'b1, 1'b0, 15, 2'b00, 1'b1, 1'b0);
        addVec("srst-r0b",    1'b1, 1'b0,  4, 2'b01, 1'b1, 1'b0);
        addVec("srst-done",   1'b1, 1'b0,  1, 2'b11, 1'b0, 1'b1);
        addVec("srst-idle",   1'b1, 1'b0,  2, 2'b11, 1'b0, 1'b0);
        // Req on the final-release edge wins; Req right after Done accepted.
        addVec("late-req",    1'b1, 1'b1,  1, 2'b00, 1'b1, 1'b0);
        addVec("late-hold",   1'b1, 1'b0, 15, 2'b00, 1'b1, 1'b0);
        addVec("late-rel0",   1'b1, 1'b0,  4, 2'b01, 1'b1, 1'b0);
        addVec("late-clash",  1'b1, 1'b1,  1, 2'b00, 1'b1, 1'b0);
        addVec("late-h2",     1'b1, 1'b0, 15, 2'b00, 1'b1, 1'b0);
        addVec("late-r0b",    1'b1, 1'b0,  4, 2'b01, 1'b1, 1'b0);
        addVec("late-done",   1'b1, 1'b0,  1, 2'b11, 1'b0, 1'b1);
        addVec("post-done-req", 1'b1, 1'b1, 1, 2'b00, 1'b1, 1'b0);
        addVec("post-hold",   1'b1, 1'b0, 15, 2'b00, 1'b1, 1'b0);
        addVec("post-rel0",   1'b1, 1'b0,  4, 2'b01, 1'b1, 1'b0);
        addVec("post-done",   1'b1, 1'b0,  1, 2'b11, 1'b0, 1'b1);
        addVec("post-idle",   1'b1, 1'b0,  2, 2'b11, 1'b0, 1'b0);

        @(posedge CLK); #1;
        monEnable = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;

        foreach (vecs[v]) begin
            applyStimulus(vecs[v].rst, vecs[v].req);
            for (int c = 0; c < vecs[v].n; c++) begin
                @(posedge CLK); #1;
                checkOutput($sformatf("A %s.%0d Rst_Out", vecs[v].name, c),
                            32'(busA.Rst_Out), 32'(vecs[v].expRst));
                checkOutput($sformatf("A %s.%0d Busy", vecs[v].name, c),
                            32'(busA.Busy), 32'(vecs[v].expBusy));
                checkOutput($sformatf("A %s.%0d Done", vecs[v].name, c),
                            32'(busA.Done), 32'(vecs[v].expDone));
            end
        end
        applyStimulus(1'b1, 1'b0);

        runB(1'b1);
        runB(1'b0);
        runC(1'b1, 0);
        runC(1'b0, 0);
        runC(1'b0, 9);

        repeat (2) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
